// File: rtl/sfq_merge_scheduler.sv
//==============================================================================
// Module   : sfq_merge_scheduler
// Summary  : Counts single-cycle pulses from N requesters and replays them one
//            per clock on a shared output in round-robin order.
// Option   : SFQ_MERGE_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sfq_merge_scheduler #(
    parameter int N  = 4,
    parameter int CW = 3,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req_pulse,
    input  logic          ovf_clr,
    output logic          q,
    output logic [SW-1:0] q_src,
    output logic          busy,
`ifdef SFQ_MERGE_DROP_CNT_EN
    output logic [7:0]    drop_cnt,
`endif
    output logic [N-1:0]  ovf
);

    localparam logic [CW-1:0] C_PEND_MAX   = {CW{1'b1}};
    localparam logic [SW-1:0] C_LAST_RESET = SW'(N - 1);

    logic [CW-1:0] pending_q [N];
    logic [CW-1:0] pending_d [N];
    logic [SW-1:0] last_grant_q;
    logic          q_q;
    logic [SW-1:0] q_src_q;
    logic [N-1:0]  ovf_q;
    logic [N-1:0]  ovf_d;

    logic          w_grant_found;
    logic [SW-1:0] w_grant_idx;
    logic [N-1:0]  w_grant_vec;
    logic [N-1:0]  w_lose;
    logic          w_busy;

    // Round-robin scan starting just after the last served requester.
    always_comb begin
        int k;
        k             = 0;
        w_grant_found = 1'b0;
        w_grant_idx   = last_grant_q;
        w_grant_vec   = '0;
        for (int off = 1; off <= N; off++) begin
            k = int'(last_grant_q) + off;
            if (k >= N) begin
                k = k - N;
            end
            if (en && !w_grant_found && (pending_q[k] != '0)) begin
                w_grant_found  = 1'b1;
                w_grant_idx    = SW'(k);
                w_grant_vec[k] = 1'b1;
            end
        end
    end

    // Inc and dec together cancel; an inc into a full counter is a loss.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pending_d[i] = pending_q[i];
            w_lose[i]    = 1'b0;
            case ({req_pulse[i], w_grant_vec[i]})
                2'b10: begin
                    if (pending_q[i] == C_PEND_MAX) begin
                        w_lose[i] = 1'b1;
                    end else begin
                        pending_d[i] = pending_q[i] + 1'b1;
                    end
                end
                2'b01:   pending_d[i] = pending_q[i] - 1'b1;
                default: pending_d[i] = pending_q[i];
            endcase
        end
    end

    // A new loss on the clearing edge keeps its bit set.
    assign ovf_d = ovf_clr ? w_lose : (ovf_q | w_lose);

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_busy = w_busy | (pending_q[i] != '0);
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pend
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending_q[gi] <= '0;
                end else begin
                    pending_q[gi] <= pending_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q          <= 1'b0;
            q_src_q      <= '0;
            last_grant_q <= C_LAST_RESET;
            ovf_q        <= '0;
        end else begin
            q_q   <= w_grant_found;
            ovf_q <= ovf_d;
            if (w_grant_found) begin
                q_src_q      <= w_grant_idx;
                last_grant_q <= w_grant_idx;
            end
        end
    end

`ifdef SFQ_MERGE_DROP_CNT_EN
    logic [7:0] drop_q;
    logic [7:0] drop_d;
    logic [8:0] w_loss_cnt;
    logic [8:0] w_drop_sum;

    always_comb begin
        w_loss_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_loss_cnt = w_loss_cnt + 9'(w_lose[i]);
        end
        w_drop_sum = (ovf_clr ? 9'd0 : {1'b0, drop_q}) + w_loss_cnt;
        drop_d     = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

    assign q     = q_q;
    assign q_src = q_src_q;
    assign busy  = w_busy;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire
